// File: rtl/riscv_mmio_pkg.sv
// Shared constants and state encoding for the MMIO store monitor.
package riscv_mmio_pkg;

    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'hFFFF_FFF0;
    localparam logic [31:0] TOHOST_ADDR_DEF  = 32'hFFFF_FFF4;
    localparam logic [31:0] TOHOST_PASS      = 32'd1;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DONE_PASS = 2'd1,
        ST_DONE_FAIL = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers, cleared by reset so the FIFO empties immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/mmio_monitor.sv
// Watches the core's data-memory store port, diverting console and tohost stores.
module mmio_monitor
    import riscv_mmio_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEF,
    parameter int          CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_write,
    input  logic [31:0]             data_addr,
    input  logic [31:0]             write_data,
    output logic                    dmem_we,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic                    done,
    output logic                    pass,
    output logic [30:0]             fail_code,
    output logic [CNT_W-1:0]        store_count
);

    mon_state_e       state_q, state_d;
    logic             overflow_q, overflow_d;
    logic [30:0]      fail_code_q, fail_code_d;
    logic [CNT_W-1:0] store_count_q, store_count_d;

    logic hit_con;
    logic hit_th;
    logic running;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;

    assign hit_con   = mem_write & (data_addr == CONSOLE_ADDR);
    assign hit_th    = mem_write & (data_addr == TOHOST_ADDR);
    assign dmem_we   = mem_write & ~hit_con & ~hit_th;
    assign running   = (state_q == ST_RUN);
    assign fifo_push = hit_con & running;
    assign out_valid = ~fifo_empty;
    assign fifo_pop  = out_valid & out_ready;

    assign done        = (state_q != ST_RUN);
    assign pass        = (state_q == ST_DONE_PASS);
    assign fail_code   = fail_code_q;
    assign overflow    = overflow_q;
    assign store_count = store_count_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (write_data[7:0]),
        .pop     (fifo_pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Termination FSM, sticky overflow flag and saturating store counter.
    always_comb begin
        state_d       = state_q;
        fail_code_d   = fail_code_q;
        overflow_d    = overflow_q | (fifo_push & fifo_full & ~fifo_pop);
        store_count_d = store_count_q;
        if (running) begin
            if (mem_write && !(&store_count_q)) begin
                store_count_d = store_count_q + CNT_W'(1);
            end
            if (hit_th) begin
                if (write_data == TOHOST_PASS) begin
                    state_d = ST_DONE_PASS;
                end else if (write_data != 32'd0) begin
                    state_d     = ST_DONE_FAIL;
                    fail_code_d = write_data[31:1];
                end
            end
        end
    end

    // Monitor state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            fail_code_q   <= '0;
            overflow_q    <= 1'b0;
            store_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
            overflow_q    <= overflow_d;
            store_count_q <= store_count_d;
        end
    end

endmodule

// File: tb/tb_mmio_monitor.sv
// Directed test of mmio_monitor: console FIFO, overflow, tohost status, counting, reset.
module tb_mmio_monitor;

    localparam logic [31:0] CON = 32'hFFFF_FFF0;
    localparam logic [31:0] TH  = 32'hFFFF_FFF4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        out_ready = 1'b0;

    logic        dmem_we, out_valid, overflow, done, pass;
    logic [7:0]  out_data;
    logic [3:0]  fifo_count;
    logic [30:0] fail_code;
    logic [15:0] store_count;

    logic        dmem_we_s, out_valid_s, overflow_s, done_s, pass_s;
    logic [7:0]  out_data_s;
    logic [3:0]  fifo_count_s;
    logic [30:0] fail_code_s;
    logic [3:0]  store_count_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mmio_monitor dut (
        .clk (clk), .reset (reset), .mem_write (mem_write), .data_addr (data_addr),
        .write_data (write_data), .dmem_we (dmem_we), .out_valid (out_valid),
        .out_ready (out_ready), .out_data (out_data), .fifo_count (fifo_count),
        .overflow (overflow), .done (done), .pass (pass), .fail_code (fail_code),
        .store_count (store_count)
    );

    mmio_monitor #(.CNT_W(4)) dut_sat (
        .clk (clk), .reset (reset), .mem_write (mem_write), .data_addr (data_addr),
        .write_data (write_data), .dmem_we (dmem_we_s), .out_valid (out_valid_s),
        .out_ready (out_ready), .out_data (out_data_s), .fifo_count (fifo_count_s),
        .overflow (overflow_s), .done (done_s), .pass (pass_s), .fail_code (fail_code_s),
        .store_count (store_count_s)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One store cycle; inputs settle mid-cycle, then the edge is taken and we sample #1 after.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic exp_we);
        mem_write  = 1'b1;
        data_addr  = addr;
        write_data = data;
        #1;
        checkOutput("dmem_we", dmem_we, exp_we);
        @(posedge clk);
        #1;
        mem_write  = 1'b0;
        data_addr  = '0;
        write_data = '0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_count"}, fifo_count, 0);
        checkOutput({tag, "_ovf"}, overflow, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_pass"}, pass, 0);
        checkOutput({tag, "_fcode"}, fail_code, 0);
        checkOutput({tag, "_scnt"}, store_count, 0);
        checkOutput({tag, "_data"}, out_data, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        checkResetState("rst");
        reset = 1'b0;

        // Normal stores pass through and are counted
        applyStimulus(32'h0000_0040, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(32'h0000_0100 + 32'(i * 4), 32'(i), 1'b1);
        checkOutput("scnt5", store_count, 5);

        // Console 'H','i' with consumer stalled
        resetDut();
        applyStimulus(CON, 32'hABCD_EF48, 1'b0);
        checkOutput("con_valid1", out_valid, 1);
        applyStimulus(CON, 32'h0000_0069, 1'b0);
        checkOutput("con_count2", fifo_count, 2);
        checkOutput("con_head", out_data, 8'h48);
        idleCycle();
        checkOutput("con_hold", out_data, 8'h48);
        out_ready = 1'b1;
        idleCycle();
        checkOutput("con_pop2", out_data, 8'h69);
        checkOutput("con_cnt1", fifo_count, 1);
        idleCycle();
        checkOutput("con_empty", out_valid, 0);
        out_ready = 1'b0;

        // Overflow: nine pushes into an eight-entry FIFO
        resetDut();
        for (int i = 0; i < 9; i++) applyStimulus(CON, 32'(i), 1'b0);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_count", fifo_count, 8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("ovf_drain%0d", i), out_data, 32'(i));
            idleCycle();
        end
        checkOutput("ovf_empty", out_valid, 0);
        checkOutput("ovf_sticky", overflow, 1);
        out_ready = 1'b0;

        // Full FIFO with simultaneous pop accepts the ninth byte
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(CON, 32'(i), 1'b0);
        out_ready = 1'b1;
        applyStimulus(CON, 32'h08, 1'b0);
        out_ready = 1'b0;
        checkOutput("fpp_ovf", overflow, 0);
        checkOutput("fpp_count", fifo_count, 8);
        out_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            checkOutput($sformatf("fpp_drain%0d", i), out_data, 32'(i));
            idleCycle();
        end
        checkOutput("fpp_empty", out_valid, 0);
        out_ready = 1'b0;

        // Tohost: zero ignored, one passes
        resetDut();
        applyStimulus(TH, 32'd0, 1'b0);
        checkOutput("th0_done", done, 0);
        applyStimulus(TH, 32'd1, 1'b0);
        checkOutput("th1_done", done, 1);
        checkOutput("th1_pass", pass, 1);

        // Tohost failure, then later writes ignored and not counted
        resetDut();
        applyStimulus(TH, 32'h0000_0007, 1'b0);
        checkOutput("thf_done", done, 1);
        checkOutput("thf_pass", pass, 0);
        checkOutput("thf_code", fail_code, 3);
        applyStimulus(TH, 32'd1, 1'b0);
        applyStimulus(CON, 32'h41, 1'b0);
        applyStimulus(32'h0000_0080, 32'h5, 1'b1);
        checkOutput("thf_pass2", pass, 0);
        checkOutput("thf_code2", fail_code, 3);
        checkOutput("thf_nocon", fifo_count, 0);
        checkOutput("thf_scnt", store_count, 1);

        // Asynchronous reset mid-operation
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(CON, 32'h61 + 32'(i), 1'b0);
        applyStimulus(TH, 32'd1, 1'b0);
        checkOutput("mid_count", fifo_count, 3);
        checkOutput("mid_done", done, 1);
        #2;
        reset = 1'b1;
        #1;
        checkResetState("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Saturating counter on the narrow instance
        for (int i = 0; i < 20; i++) applyStimulus(32'h0000_0200, 32'(i), 1'b1);
        checkOutput("sat_wide", store_count, 20);
        checkOutput("sat_narrow", store_count_s, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
